// File: rtl/signal_order_gen.sv
// signal_order_gen: turns zone entries into position-limited buy/sell orders with a post-order cooldown
module signal_order_gen #(
    parameter int MAX_POS = 3,
    parameter int COOLDOWN_CYCLES = 8,
    parameter int POS_W = $clog2(MAX_POS + 1) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              sig,
    output logic                    order_valid,
    input  logic                    order_ready,
    output logic                    order_side,
    output logic signed [POS_W-1:0] position,
    output logic                    cooldown_active,
    output logic [7:0]              dropped_cnt
);
    localparam int CW = COOLDOWN_CYCLES > 1 ? $clog2(COOLDOWN_CYCLES) : 1;
    localparam logic [CW-1:0] CD_INIT = CW'(COOLDOWN_CYCLES > 0 ? COOLDOWN_CYCLES - 1 : 0);
    localparam logic signed [POS_W-1:0] POS_MAX = POS_W'(MAX_POS);
    localparam logic signed [POS_W-1:0] ONE = POS_W'(1);

    if (MAX_POS < 1) begin : g_bad_max_pos
        $error("signal_order_gen: MAX_POS must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, PENDING, COOLDOWN} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    sig_q;
    logic          buy_evt, sell_evt, accept, handshake;

    assign buy_evt         = sig == 2'b10 && sig_q != 2'b10;
    assign sell_evt        = sig == 2'b11 && sig_q != 2'b11;
    assign accept          = state == IDLE && (buy_evt ? position < POS_MAX : sell_evt && position > -POS_MAX);
    assign order_valid     = state == PENDING;
    assign cooldown_active = state == COOLDOWN;
    assign handshake       = order_valid && order_ready;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE:     state_n = accept ? PENDING : IDLE;
            PENDING: begin
                state_n = handshake ? (COOLDOWN_CYCLES == 0 ? IDLE : COOLDOWN) : PENDING;
                cnt_n   = handshake ? CD_INIT : cnt;
            end
            COOLDOWN: begin
                state_n = cnt == '0 ? IDLE : COOLDOWN;
                cnt_n   = cnt == '0 ? cnt : cnt - CW'(1);
            end
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            sig_q       <= 2'b00;
            order_side  <= 1'b0;
            position    <= '0;
            dropped_cnt <= 8'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            sig_q <= sig;
            if (accept)
                order_side <= buy_evt;
            if (handshake)
                position <= position + (order_side ? ONE : -ONE);
            if ((buy_evt || sell_evt) && !accept && dropped_cnt != 8'hFF)
                dropped_cnt <= dropped_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_signal_order_gen.sv
// tb_signal_order_gen: directed and randomized checks of two configurations (cooldown 8 and 0) against a cycle-count model
module tb_signal_order_gen;
    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             order_ready = 1'b0;
    logic [1:0]       sig = 2'b00;
    logic             valid [2];
    logic             side [2];
    logic             cool [2];
    logic signed [2:0] pos [2];
    logic [7:0]       drop [2];

    int total = 0, passed = 0, cyc = 0;
    int m_pos [2], m_drop [2], m_free [2];
    bit m_pend [2], m_side [2];
    logic [1:0] m_prev = 2'b00;

    always #5 clk = ~clk;

    signal_order_gen dut (
        .clk(clk), .reset(reset), .sig(sig), .order_valid(valid[0]), .order_ready(order_ready),
        .order_side(side[0]), .position(pos[0]), .cooldown_active(cool[0]), .dropped_cnt(drop[0])
    );

    signal_order_gen #(.COOLDOWN_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .sig(sig), .order_valid(valid[1]), .order_ready(order_ready),
        .order_side(side[1]), .position(pos[1]), .cooldown_active(cool[1]), .dropped_cnt(drop[1])
    );

    // Model: a unit is free to take an order once no order is pending and the edge index reaches m_free.
    task automatic step();
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            bit buy, sell, idle;
            if (reset) begin
                m_pos[k] = 0; m_drop[k] = 0; m_free[k] = 0; m_pend[k] = 0; m_side[k] = 0;
            end else begin
                buy  = sig == 2'b10 && m_prev != 2'b10;
                sell = sig == 2'b11 && m_prev != 2'b11;
                idle = !m_pend[k] && cyc >= m_free[k];
                if (m_pend[k] && order_ready) begin
                    m_pos[k] += m_side[k] ? 1 : -1;
                    m_pend[k] = 0;
                    m_free[k] = cyc + (k == 0 ? 8 : 0) + 1;
                end
                if (buy || sell) begin
                    if (idle && (buy ? m_pos[k] < 3 : m_pos[k] > -3)) begin
                        m_pend[k] = 1;
                        m_side[k] = buy;
                    end else if (m_drop[k] < 255) m_drop[k]++;
                end
            end
        end
        m_prev = reset ? 2'b00 : sig;
        cyc++;
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1; sig = 2'b00; order_ready = 1'b0;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        for (int k = 0; k < 2; k++) begin
            total++;
            if ({valid[k], side[k], cool[k], pos[k], drop[k]} !== 14'd0)
                $display("FAIL reset dut%0d: got %h want 0", k, {valid[k], side[k], cool[k], pos[k], drop[k]});
            else passed++;
        end
    endtask

    task automatic test_buy_basic();
        int n;
        apply_reset();
        order_ready = 1'b1;
        sig = 2'b01; step();
        sig = 2'b10; step();
        total++;
        if ({valid[0], side[0]} !== 2'b11) $display("FAIL basic_issue: got %b want 11", {valid[0], side[0]});
        else passed++;
        step();
        total++;
        if ({valid[0], cool[0], pos[0]} !== {2'b01, 3'sd1}) $display("FAIL basic_hs: got %b want 01001", {valid[0], cool[0], pos[0]});
        else passed++;
        total++;
        if ({cool[1], pos[1]} !== {1'b0, 3'sd1}) $display("FAIL basic_hs_cd0: got %b want 0001", {cool[1], pos[1]});
        else passed++;
        n = 0;
        while (cool[0] && n < 20) begin n++; step(); end
        total++;
        if (n != 8) $display("FAIL basic_cooldown_len: got %0d want 8", n);
        else passed++;
    endtask

    task automatic test_hold_sell();
        logic [1:0] seq [4] = '{2'b01, 2'b10, 2'b01, 2'b11};
        apply_reset();
        sig = 2'b01; step();
        sig = 2'b11; step();
        total++;
        if ({valid[0], side[0]} !== 2'b10) $display("FAIL hold_issue: got %b want 10", {valid[0], side[0]});
        else passed++;
        for (int i = 0; i < 20; i++) begin
            sig = i < 4 ? seq[i] : 2'b01;
            step();
            total++;
            if ({valid[0], side[0], pos[0]} !== 5'b10000) $display("FAIL hold_stable %0d: got %b want 10000", i, {valid[0], side[0], pos[0]});
            else passed++;
        end
        total++;
        if (drop[0] !== 8'd2) $display("FAIL hold_dropped: got %0d want 2", drop[0]);
        else passed++;
        order_ready = 1'b1; step();
        total++;
        if ({valid[0], pos[0]} !== {1'b0, -3'sd1}) $display("FAIL hold_release: got %b want 0111", {valid[0], pos[0]});
        else passed++;
    endtask

    task automatic test_limit();
        apply_reset();
        order_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sig = 2'b01; step();
            sig = 2'b10; step(); step();
            sig = 2'b01;
            for (int j = 0; j < 10; j++) step();
            total++;
            if ({pos[0], drop[0]} !== {3'(i < 3 ? i + 1 : 3), 8'(i == 3)})
                $display("FAIL limit %0d: got pos %0d drop %0d want pos %0d drop %0d", i, pos[0], drop[0], i < 3 ? i + 1 : 3, i == 3);
            else passed++;
        end
        sig = 2'b11; step(); step();
        total++;
        if (pos[0] !== 3'sd2) $display("FAIL limit_sell: got %0d want 2", pos[0]);
        else passed++;
    endtask

    task automatic test_hold_low();
        int n;
        apply_reset();
        order_ready = 1'b1;
        sig = 2'b01; step();
        sig = 2'b10;
        n = 0;
        for (int i = 0; i < 50; i++) begin step(); if (valid[0]) n++; end
        total++;
        if (n != 1) $display("FAIL hold_low_orders: got %0d want 1", n);
        else passed++;
        sig = 2'b11; step();
        total++;
        if ({valid[0], side[0]} !== 2'b10) $display("FAIL direct_sell: got %b want 10", {valid[0], side[0]});
        else passed++;
        step();
        total++;
        if (pos[0] !== 3'sd0) $display("FAIL direct_sell_pos: got %0d want 0", pos[0]);
        else passed++;
    endtask

    task automatic test_cooldown0();
        apply_reset();
        order_ready = 1'b1;
        sig = 2'b01; step();
        sig = 2'b10; step();
        total++;
        if (valid[1] !== 1'b1) $display("FAIL cd0_issue: got %b want 1", valid[1]);
        else passed++;
        sig = 2'b01; step();
        total++;
        if ({valid[1], cool[1], pos[1]} !== {2'b00, 3'sd1}) $display("FAIL cd0_hs: got %b want 00001", {valid[1], cool[1], pos[1]});
        else passed++;
        sig = 2'b11; step();
        total++;
        if ({valid[1], side[1]} !== 2'b10) $display("FAIL cd0_next: got %b want 10", {valid[1], side[1]});
        else passed++;
        sig = 2'b10; step();
        total++;
        if ({valid[1], pos[1], drop[1]} !== {1'b0, 3'sd0, 8'd1})
            $display("FAIL cd0_hs_edge: got valid %b pos %0d drop %0d want 0 0 1", valid[1], pos[1], drop[1]);
        else passed++;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        sig = 2'b01; step();
        sig = 2'b10; step();
        sig = 2'b01; step();
        sig = 2'b11; step();
        total++;
        if ({valid[0], drop[0]} !== {1'b1, 8'd1}) $display("FAIL mid_pre: got %h want 101", {valid[0], drop[0]});
        else passed++;
        reset = 1'b1; step(); reset = 1'b0;
        total++;
        if ({valid[0], cool[0], pos[0], drop[0]} !== 13'd0) $display("FAIL mid_reset: got %h want 0", {valid[0], cool[0], pos[0], drop[0]});
        else passed++;
        sig = 2'b01; step();
        sig = 2'b10; step();
        for (int i = 0; i < 300; i++) begin
            sig = 2'b01; step();
            sig = 2'b11; step();
        end
        for (int k = 0; k < 2; k++) begin
            total++;
            if (drop[k] !== 8'd255) $display("FAIL saturate dut%0d: got %0d want 255", k, drop[k]);
            else passed++;
        end
    endtask

    task automatic test_random();
        logic [14:0] act, exp;
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            sig = 2'($urandom_range(0, 3));
            order_ready = $urandom_range(0, 2) != 0;
            reset = $urandom_range(0, 299) == 0;
            step();
            for (int k = 0; k < 2; k++) begin
                act = {valid[k], valid[k] & side[k], cool[k], pos[k], drop[k], 1'b0};
                exp = {m_pend[k], m_pend[k] & m_side[k], !m_pend[k] && cyc < m_free[k], 3'(m_pos[k]), 8'(m_drop[k]), 1'b0};
                total++;
                if (act !== exp) $display("FAIL random dut%0d iter %0d: got %h want %h", k, i, act, exp);
                else passed++;
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_buy_basic();
        test_hold_sell();
        test_limit();
        test_hold_low();
        test_cooldown0();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
